// File: rtl/mem_arb_pkg.sv
// mem_arb_pkg: types and constants shared by the memory request arbiter.
//   state_t      - arbiter FSM states
//   ARB_FIXED/RR - arbitration mode selectors for the RR_MODE parameter
//   gid_width()  - width of a port index (at least 1 bit)
package mem_arb_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        WAIT   = 2'd2,
        DONE   = 2'd3
    } state_t;

    localparam int ARB_FIXED = 0;
    localparam int ARB_RR    = 1;

    // A single port still needs a 1-bit index so grant_id is never zero-width.
    function automatic int gid_width(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/arb_pick.sv
// arb_pick: combinational winner selection among requesting ports.
//   req     - per-port request vector
//   rr_ptr  - index of the port served last (round-robin reference)
//   rr_mode - 0: lowest index wins, 1: search upward from rr_ptr+1 with wrap
//   winner  - selected port index (0 when nothing is requesting)
//   any_req - at least one request bit is set
module arb_pick
    import mem_arb_pkg::*;
#(
    parameter int NUM_PORTS = 2,
    parameter int GID_W     = gid_width(NUM_PORTS)
) (
    input  logic [NUM_PORTS-1:0] req,
    input  logic [GID_W-1:0]     rr_ptr,
    input  logic                 rr_mode,
    output logic [GID_W-1:0]     winner,
    output logic                 any_req
);

    // rr_order[k] is the port examined k-th in round-robin mode:
    // (rr_ptr + 1 + k) mod NUM_PORTS, so the last-served port is checked last.
    logic [GID_W-1:0] rr_order [NUM_PORTS];
    logic             found;

    genvar gi;
    generate
        for (gi = 0; gi < NUM_PORTS; gi++) begin : g_order
            assign rr_order[gi] = GID_W'((int'(rr_ptr) + 1 + gi) % NUM_PORTS);
        end
    endgenerate

    always_comb begin
        winner = '0;
        found  = 1'b0;
        for (int i = 0; i < NUM_PORTS; i++) begin
            if (rr_mode) begin
                if (!found && req[rr_order[i]]) begin
                    winner = rr_order[i];
                    found  = 1'b1;
                end
            end else if (!found && req[i]) begin
                winner = GID_W'(i);
                found  = 1'b1;
            end
        end
        any_req = |req;
    end

endmodule

// File: rtl/mem_arbiter.sv
// mem_arbiter: shares one single-port RAM among NUM_PORTS requestors with a
// valid/done handshake. One transaction at a time: IDLE -> ACCESS -> (WAIT) -> DONE.
//   clk, rst                 - clock, asynchronous active-high reset
//   req_valid/write/addr/wdata - per-port requests (addr/wdata packed per port)
//   resp_done                - one-cycle completion pulse for the served port
//   resp_rdata               - last load data, valid with resp_done, held otherwise
//   busy                     - high whenever the FSM is not in IDLE
//   grant_id                 - index of the current or last served port
//   ram_addr/wdata/wen/ren   - RAM command (all registered)
//   ram_rdata                - RAM read data, valid RAM_LATENCY cycles after ram_ren
module mem_arbiter
    import mem_arb_pkg::*;
#(
    parameter int NUM_PORTS   = 2,
    parameter int ADDR_W      = 12,
    parameter int DATA_W      = 32,
    parameter int RAM_LATENCY = 1,
    parameter int RR_MODE     = 0,
    localparam int GID_W      = gid_width(NUM_PORTS)
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic [NUM_PORTS-1:0]        req_valid,
    input  logic [NUM_PORTS-1:0]        req_write,
    input  logic [NUM_PORTS*ADDR_W-1:0] req_addr,
    input  logic [NUM_PORTS*DATA_W-1:0] req_wdata,
    output logic [NUM_PORTS-1:0]        resp_done,
    output logic [DATA_W-1:0]           resp_rdata,
    output logic                        busy,
    output logic [GID_W-1:0]            grant_id,
    output logic [ADDR_W-1:0]           ram_addr,
    output logic [DATA_W-1:0]           ram_wdata,
    output logic                        ram_wen,
    output logic                        ram_ren,
    input  logic [DATA_W-1:0]           ram_rdata
);

    localparam int   CNT_W = 3;   // holds RAM_LATENCY up to 4
    localparam logic RR_EN = (RR_MODE == ARB_RR);

    state_t               state_reg;
    logic [CNT_W-1:0]     cnt_reg;
    logic                 wr_reg;
    logic [GID_W-1:0]     grant_reg;
    logic [GID_W-1:0]     rr_ptr_reg;
    logic [NUM_PORTS-1:0] resp_done_reg;
    logic [DATA_W-1:0]    resp_rdata_reg;
    logic                 busy_reg;
    logic [ADDR_W-1:0]    ram_addr_reg;
    logic [DATA_W-1:0]    ram_wdata_reg;
    logic                 ram_wen_reg;
    logic                 ram_ren_reg;

    logic [GID_W-1:0]     pick_id;
    logic                 any_req;

    // Per-port views of the packed request buses.
    logic [ADDR_W-1:0]    addr_arr  [NUM_PORTS];
    logic [DATA_W-1:0]    wdata_arr [NUM_PORTS];

    genvar gi;
    generate
        for (gi = 0; gi < NUM_PORTS; gi++) begin : g_unpack
            assign addr_arr[gi]  = req_addr[gi*ADDR_W +: ADDR_W];
            assign wdata_arr[gi] = req_wdata[gi*DATA_W +: DATA_W];
        end
    endgenerate

    arb_pick #(
        .NUM_PORTS (NUM_PORTS),
        .GID_W     (GID_W)
    ) u_pick (
        .req     (req_valid),
        .rr_ptr  (rr_ptr_reg),
        .rr_mode (RR_EN),
        .winner  (pick_id),
        .any_req (any_req)
    );

    // Every output is registered: strobes and busy are set on the edge that
    // enters the state they belong to, so they line up with the state itself.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg      <= IDLE;
            cnt_reg        <= '0;
            wr_reg         <= 1'b0;
            grant_reg      <= '0;
            rr_ptr_reg     <= GID_W'(NUM_PORTS - 1);
            resp_done_reg  <= '0;
            resp_rdata_reg <= '0;
            busy_reg       <= 1'b0;
            ram_addr_reg   <= '0;
            ram_wdata_reg  <= '0;
            ram_wen_reg    <= 1'b0;
            ram_ren_reg    <= 1'b0;
        end else begin
            resp_done_reg <= '0;
            case (state_reg)
                IDLE: begin
                    if (any_req) begin
                        // Request fields are captured only here; later changes
                        // on the request buses do not affect this transaction.
                        grant_reg     <= pick_id;
                        wr_reg        <= req_write[pick_id];
                        ram_addr_reg  <= addr_arr[pick_id];
                        ram_wdata_reg <= wdata_arr[pick_id];
                        ram_wen_reg   <= req_write[pick_id];
                        ram_ren_reg   <= ~req_write[pick_id];
                        busy_reg      <= 1'b1;
                        state_reg     <= ACCESS;
                    end
                end
                ACCESS: begin
                    ram_wen_reg <= 1'b0;
                    ram_ren_reg <= 1'b0;
                    if (wr_reg) begin
                        resp_done_reg[grant_reg] <= 1'b1;
                        state_reg                <= DONE;
                    end else begin
                        cnt_reg   <= CNT_W'(RAM_LATENCY);
                        state_reg <= WAIT;
                    end
                end
                WAIT: begin
                    // Counter value 1 marks the cycle in which ram_rdata is valid.
                    if (cnt_reg == CNT_W'(1)) begin
                        resp_rdata_reg           <= ram_rdata;
                        resp_done_reg[grant_reg] <= 1'b1;
                        state_reg                <= DONE;
                    end else begin
                        cnt_reg <= cnt_reg - 1'b1;
                    end
                end
                DONE: begin
                    if (RR_EN) begin
                        rr_ptr_reg <= grant_reg;
                    end
                    busy_reg  <= 1'b0;
                    state_reg <= IDLE;
                end
                default: begin
                    state_reg <= IDLE;
                end
            endcase
        end
    end

    assign resp_done  = resp_done_reg;
    assign resp_rdata = resp_rdata_reg;
    assign busy       = busy_reg;
    assign grant_id   = grant_reg;
    assign ram_addr   = ram_addr_reg;
    assign ram_wdata  = ram_wdata_reg;
    assign ram_wen    = ram_wen_reg;
    assign ram_ren    = ram_ren_reg;

endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: four arbiter instances (3 ports each) with RAM latency 1..4,
// even configs fixed priority, odd configs round-robin. Each instance has its
// own latency-accurate RAM model. Table vectors, hand sequences and random
// multi-port traffic are checked against a transaction-level reference model.
module tb_mem_arbiter;

    localparam int NCFG = 4;
    localparam int NP   = 3;
    localparam int AW   = 12;
    localparam int DW   = 32;
    localparam int GW   = 2;

    logic clk = 1'b0;
    logic rst;

    logic [NP-1:0]    req_valid [NCFG];
    logic [NP-1:0]    req_write [NCFG];
    logic [NP*AW-1:0] req_addr  [NCFG];
    logic [NP*DW-1:0] req_wdata [NCFG];
    logic [NP-1:0]    resp_done [NCFG];
    logic [DW-1:0]    resp_rdata[NCFG];
    logic             busy      [NCFG];
    logic [GW-1:0]    grant_id  [NCFG];
    logic [AW-1:0]    ram_addr  [NCFG];
    logic [DW-1:0]    ram_wdata [NCFG];
    logic             ram_wen   [NCFG];
    logic             ram_ren   [NCFG];
    logic [DW-1:0]    ram_rdata [NCFG];

    logic             pl_en   [NCFG];
    logic [AW-1:0]    pl_addr [NCFG];
    logic [DW-1:0]    pl_data [NCFG];

    int checks;
    int failures;

    // Reference state: RAM image, last load value, last served port (RR).
    logic [DW-1:0] ref_mem [NCFG][4096];
    logic [DW-1:0] last_rd [NCFG];
    int            rr_last [NCFG];

    typedef struct {
        int          cfg;
        int          port;
        bit          wr;
        logic [11:0] addr;
        logic [31:0] wdata;
        logic [31:0] exp_rd;
    } vec_t;

    vec_t vecs [11];

    always #5 clk = ~clk;

    genvar gi;
    generate
        for (gi = 0; gi < NCFG; gi++) begin : g_cfg
            localparam int LAT = gi + 1;
            logic [DW-1:0] mem  [4096];
            logic [DW-1:0] pipe [4];

            mem_arbiter #(
                .NUM_PORTS   (NP),
                .ADDR_W      (AW),
                .DATA_W      (DW),
                .RAM_LATENCY (LAT),
                .RR_MODE     (gi % 2)
            ) dut (
                .clk        (clk),
                .rst        (rst),
                .req_valid  (req_valid[gi]),
                .req_write  (req_write[gi]),
                .req_addr   (req_addr[gi]),
                .req_wdata  (req_wdata[gi]),
                .resp_done  (resp_done[gi]),
                .resp_rdata (resp_rdata[gi]),
                .busy       (busy[gi]),
                .grant_id   (grant_id[gi]),
                .ram_addr   (ram_addr[gi]),
                .ram_wdata  (ram_wdata[gi]),
                .ram_wen    (ram_wen[gi]),
                .ram_ren    (ram_ren[gi]),
                .ram_rdata  (ram_rdata[gi])
            );

            // RAM whose read data appears exactly LAT cycles after the ren cycle;
            // any other cycle shows a poison value.
            always @(posedge clk) begin
                if (pl_en[gi]) mem[pl_addr[gi]] <= pl_data[gi];
                else if (ram_wen[gi]) mem[ram_addr[gi]] <= ram_wdata[gi];
                pipe[0] <= ram_ren[gi] ? mem[ram_addr[gi]] : 32'hBADBAD00;
                for (int s = 1; s < 4; s++) pipe[s] <= pipe[s-1];
            end
            assign ram_rdata[gi] = pipe[LAT-1];
        end
    endgenerate

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic set_req(input int c, input int p, input bit wr, input logic [11:0] a,
                           input logic [31:0] d);
        req_write[c][p]          = wr;
        req_addr[c][p*AW +: AW]  = a;
        req_wdata[c][p*DW +: DW] = d;
        req_valid[c][p]          = 1'b1;
    endtask

    task automatic preload(input int c, input logic [11:0] a, input logic [31:0] d);
        @(posedge clk);
        #1;
        pl_en[c] = 1'b1; pl_addr[c] = a; pl_data[c] = d;
        ref_mem[c][a] = d;
        @(posedge clk);
        #1;
        pl_en[c] = 1'b0;
    endtask

    task automatic model_reset();
        for (int c = 0; c < NCFG; c++) begin
            last_rd[c] = '0;
            rr_last[c] = NP - 1;
        end
    endtask

    task automatic apply_reset();
        @(posedge clk);
        #1 rst = 1'b1;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        model_reset();
    endtask

    // Reference arbitration: fixed = lowest pending port, RR = first pending
    // port after the last served one, wrapping.
    function automatic int model_pick(input int c, input logic [NP-1:0] pend);
        int r;
        r = -1;
        if (c % 2 == 0) begin
            for (int i = NP - 1; i >= 0; i--) if (pend[i]) r = i;
        end else begin
            for (int i = NP; i >= 1; i--) if (pend[(rr_last[c] + i) % NP]) r = (rr_last[c] + i) % NP;
        end
        return r;
    endfunction

    // One transaction on an otherwise idle instance; starts in an IDLE cycle (k=0).
    task automatic do_txn(input int c, input int p, input bit wr, input logic [11:0] a,
                          input logic [31:0] d, input logic [31:0] exp_rd,
                          input int chg_k, input logic [11:0] chg_a, input string tag);
        int  lat;
        int  exp_k;
        bit  seen;
        lat   = c + 1;
        exp_k = wr ? 2 : 2 + lat;
        seen  = 1'b0;
        set_req(c, p, wr, a, d);
        for (int k = 0; k <= exp_k + 2 && !seen; k++) begin
            @(negedge clk);
            if (k == 0) chk({tag, "_idle_busy"}, 32'(busy[c]), 32'd0);
            if (k >= 1 && k <= exp_k) chk({tag, "_busy"}, 32'(busy[c]), 32'd1);
            if (k == 1) begin
                chk({tag, "_acc_strobes"}, 32'({ram_wen[c], ram_ren[c]}), wr ? 32'd2 : 32'd1);
                chk({tag, "_acc_addr"}, 32'(ram_addr[c]), 32'(a));
                if (wr) chk({tag, "_acc_wdata"}, ram_wdata[c], d);
            end
            if (!wr && k >= 2 && k <= 1 + lat) begin
                chk({tag, "_wait_strobes"}, 32'({ram_wen[c], ram_ren[c]}), 32'd0);
                chk({tag, "_wait_addr"}, 32'(ram_addr[c]), 32'(a));
            end
            if (resp_done[c] != '0 || k == exp_k) begin
                seen = 1'b1;
                chk({tag, "_done_vec"}, 32'(resp_done[c]), 32'(1 << p));
                chk({tag, "_done_cycle"}, 32'(k), 32'(exp_k));
                chk({tag, "_grant_id"}, 32'(grant_id[c]), 32'(p));
                if (wr) begin
                    chk({tag, "_rdata_held"}, resp_rdata[c], last_rd[c]);
                    ref_mem[c][a] = d;
                end else begin
                    chk({tag, "_rdata"}, resp_rdata[c], exp_rd);
                    last_rd[c] = exp_rd;
                end
                rr_last[c] = p;
                $display("txn %s cfg=%0d port=%0d wr=%0d addr=0x%03h rdata=0x%08h done_k=%0d",
                         tag, c, p, wr, a, resp_rdata[c], k);
            end
            if (k == chg_k) req_addr[c][p*AW +: AW] = chg_a;
        end
        @(posedge clk);
        #1 req_valid[c][p] = 1'b0;
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int n0, n1, cnt;
        bit any_done;
        checks   = 0;
        failures = 0;
        rst      = 1'b1;
        for (int c = 0; c < NCFG; c++) begin
            req_valid[c] = '0; req_write[c] = '0; req_addr[c] = '0; req_wdata[c] = '0;
            pl_en[c] = 1'b0; pl_addr[c] = '0; pl_data[c] = '0;
        end
        model_reset();

        vecs[0]  = '{0, 1, 1'b0, 12'h010, 32'h0,        32'hDEADBEEF};
        vecs[1]  = '{0, 0, 1'b1, 12'h004, 32'h12345678, 32'h0};
        vecs[2]  = '{0, 2, 1'b0, 12'h004, 32'h0,        32'h12345678};
        vecs[3]  = '{0, 1, 1'b1, 12'h008, 32'hCAFEF00D, 32'h0};
        vecs[4]  = '{0, 0, 1'b0, 12'h008, 32'h0,        32'hCAFEF00D};
        vecs[5]  = '{0, 2, 1'b0, 12'h040, 32'h0,        32'hA0000040};
        vecs[6]  = '{1, 2, 1'b0, 12'h041, 32'h0,        32'hA0000041};
        vecs[7]  = '{2, 2, 1'b0, 12'h042, 32'h0,        32'hA0000042};
        vecs[8]  = '{3, 2, 1'b0, 12'h043, 32'h0,        32'hA0000043};
        vecs[9]  = '{1, 0, 1'b1, 12'h044, 32'h55AA55AA, 32'h0};
        vecs[10] = '{1, 1, 1'b0, 12'h044, 32'h0,        32'h55AA55AA};

        // Reset values while reset is held.
        repeat (3) @(posedge clk);
        @(negedge clk);
        for (int c = 0; c < NCFG; c++) begin
            chk("rst_busy",      32'(busy[c]),      32'd0);
            chk("rst_resp_done", 32'(resp_done[c]), 32'd0);
            chk("rst_strobes",   32'({ram_wen[c], ram_ren[c]}), 32'd0);
            chk("rst_grant_id",  32'(grant_id[c]),  32'd0);
            chk("rst_rdata",     resp_rdata[c],     32'd0);
            chk("rst_ram_addr",  32'(ram_addr[c]),  32'd0);
            chk("rst_ram_wdata", ram_wdata[c],      32'd0);
        end
        @(posedge clk);
        #1 rst = 1'b0;

        preload(0, 12'h010, 32'hDEADBEEF);
        for (int c = 0; c < NCFG; c++) preload(c, 12'h040 + 12'(c), 32'hA0000040 + 32'(c));
        preload(3, 12'h020, 32'h20202020);
        preload(3, 12'h030, 32'h30303030);

        // Table-driven single transactions, including the latency sweep.
        for (int v = 0; v < 11; v++)
            do_txn(vecs[v].cfg, vecs[v].port, vecs[v].wr, vecs[v].addr, vecs[v].wdata,
                   vecs[v].exp_rd, -1, 12'h0, $sformatf("vec%0d", v));

        // Address changed mid-WAIT must not affect the transaction.
        do_txn(3, 0, 1'b0, 12'h020, 32'h0, 32'h20202020, 3, 12'h030, "chg_wait");

        // Reset during WAIT: everything drops at once, no done, then a fresh serve.
        set_req(2, 1, 1'b0, 12'h042, 32'h0);
        for (int k = 0; k <= 3; k++) @(negedge clk);
        #2 rst = 1'b1;
        #1;
        chk("midrst_strobes", 32'({ram_wen[2], ram_ren[2]}), 32'd0);
        chk("midrst_busy",    32'(busy[2]),      32'd0);
        chk("midrst_done",    32'(resp_done[2]), 32'd0);
        any_done = 1'b0;
        repeat (2) begin
            @(negedge clk);
            if (resp_done[2] != '0) any_done = 1'b1;
        end
        chk("midrst_no_pulse", 32'(any_done), 32'd0);
        @(posedge clk);
        #1 rst = 1'b0;
        model_reset();
        do_txn(2, 1, 1'b0, 12'h042, 32'h0, 32'hA0000042, -1, 12'h0, "rst_retry");

        // Fixed priority: port 0 held continuously starves port 1.
        set_req(0, 0, 1'b1, 12'h200, 32'h11111111);
        set_req(0, 1, 1'b1, 12'h201, 32'h22222222);
        n0 = 0; n1 = 0;
        for (int k = 0; k < 30; k++) begin
            @(negedge clk);
            if (resp_done[0][0]) n0++;
            if (resp_done[0][1]) n1++;
        end
        @(posedge clk);
        #1 req_valid[0] = '0;
        ref_mem[0][12'h200] = 32'h11111111;
        chk("fixed_port0_served", 32'(n0), 32'd10);
        chk("fixed_port1_starved", 32'(n1), 32'd0);
        $display("txn fixed_prio cfg=0 port0_done=%0d port1_done=%0d", n0, n1);

        // Round-robin from reset with all ports requesting: 0,1,2,0,1,2.
        apply_reset();
        for (int p = 0; p < NP; p++) set_req(1, p, 1'b1, 12'h300 + 12'(p), 32'h33330000 + 32'(p));
        cnt = 0;
        for (int k = 0; k < 60 && cnt < 6; k++) begin
            @(negedge clk);
            if (resp_done[1] != '0) begin
                chk($sformatf("rr_order%0d", cnt), 32'(resp_done[1]), 32'(1 << (cnt % 3)));
                $display("txn rr_order cfg=1 idx=%0d done=%b", cnt, resp_done[1]);
                cnt++;
            end
        end
        @(posedge clk);
        #1 req_valid[1] = '0;
        chk("rr_order_count", 32'(cnt), 32'd6);
        for (int p = 0; p < NP; p++) ref_mem[1][12'h300 + 12'(p)] = 32'h33330000 + 32'(p);

        // Random multi-port traffic against the reference model.
        apply_reset();
        for (int c = 0; c < 2; c++)
            for (int a = 0; a < 8; a++) preload(c, 12'h100 + 12'(a), $urandom);
        for (int c = 0; c < 2; c++) begin
            for (int r = 0; r < 15; r++) begin
                logic [NP-1:0] pend;
                bit            pw [NP];
                logic [11:0]   pa [NP];
                logic [31:0]   pd [NP];
                int            ep, ek, k;
                bit            ok;
                pend = NP'($urandom_range(1, 7));
                for (int p = 0; p < NP; p++) begin
                    pw[p] = 1'($urandom_range(0, 1));
                    pa[p] = 12'h100 + 12'($urandom_range(0, 7));
                    pd[p] = $urandom;
                    if (pend[p]) set_req(c, p, pw[p], pa[p], pd[p]);
                end
                ep = model_pick(c, pend);
                ek = 2 + (pw[ep] ? 0 : c + 1);
                k  = -1;
                ok = 1'b1;
                while (pend != '0 && ok) begin
                    @(negedge clk);
                    k++;
                    if (resp_done[c] != '0 || k == ek) begin
                        ok = (resp_done[c] == NP'(1 << ep)) && (k == ek);
                        chk("rnd_done_vec", 32'(resp_done[c]), 32'(1 << ep));
                        chk("rnd_done_cycle", 32'(k), 32'(ek));
                        if (pw[ep]) begin
                            chk("rnd_rdata_held", resp_rdata[c], last_rd[c]);
                            ref_mem[c][pa[ep]] = pd[ep];
                        end else begin
                            chk("rnd_load_data", resp_rdata[c], ref_mem[c][pa[ep]]);
                            last_rd[c] = ref_mem[c][pa[ep]];
                        end
                        $display("txn rnd cfg=%0d round=%0d port=%0d wr=%0d addr=0x%03h rdata=0x%08h",
                                 c, r, ep, pw[ep], pa[ep], resp_rdata[c]);
                        rr_last[c] = ep;
                        pend[ep]   = 1'b0;
                        @(posedge clk);
                        #1 req_valid[c][ep] = 1'b0;
                        if (pend != '0) begin
                            ek = k + 3 + (pw[model_pick(c, pend)] ? 0 : c + 1);
                            ep = model_pick(c, pend);
                        end
                    end
                end
                if (!ok) begin
                    req_valid[c] = '0;
                    apply_reset();
                end
            end
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
